// File: rtl/opc5ls_sysbus.sv
// OPC5LS bus responder: async-read word RAM plus an I/O page holding a
// byte-serial TX port (small FIFO + serialiser) and a free-running cycle timer.
module opc5ls_sysbus #(
  parameter int RAM_AW       = 11,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  input  logic        rnw,
  output logic [15:0] rdata,
  output logic        txd
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int LW    = FIFO_AW + 1;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BCNT_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [15:0] TXDATA_A = 16'hFE00;
  localparam logic [15:0] STATUS_A = 16'hFE01;
  localparam logic [15:0] TIMER_A  = 16'hFE02;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  logic [15:0]        ram_q [0:(1<<RAM_AW)-1];
  logic [7:0]         fifo_q [0:DEPTH-1];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic [15:0]        count_q, count_d;
  tx_state_e          state_q, state_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [2:0]         bidx_q, bidx_d;
  logic [7:0]         sh_q, sh_d;
  logic               txd_q, txd_d;

  logic is_ram, wr_en, wr_tx, fifo_full, fifo_empty, push, pop, empty_bit;

  assign is_ram     = (address >> RAM_AW) == 16'd0;
  assign wr_en      = !rnw;
  assign wr_tx      = wr_en && (address == TXDATA_A);
  assign fifo_full  = (level_q == LW'(DEPTH));
  assign fifo_empty = (level_q == '0);
  // A full FIFO drops the byte even when the serialiser pops on the same edge.
  assign push       = wr_tx && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign empty_bit  = fifo_empty && (state_q == S_IDLE);
  assign txd        = txd_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
    ovf_d = ovf_q;
    if (wr_tx && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr_en && (address == STATUS_A)) begin
      ovf_d = 1'b0;
    end
    count_d = (wr_en && (address == TIMER_A)) ? wdata : count_q + 16'd1;
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          sh_d    = fifo_q[rd_ptr_q];
          bcnt_d  = BCNT_MAX;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bcnt_q == '0) begin
          bcnt_d  = BCNT_MAX;
          bidx_d  = 3'd0;
          state_d = S_DATA;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (bcnt_q == '0) begin
          bcnt_d = BCNT_MAX;
          sh_d   = {1'b0, sh_q[7:1]};
          if (bidx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
      default: begin
        if (bcnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          bcnt_d = bcnt_q - 1'b1;
        end
      end
    endcase
    // Line level follows the next state so txd leaves a flop.
    txd_d = 1'b1;
    if (state_d == S_START) begin
      txd_d = 1'b0;
    end else if (state_d == S_DATA) begin
      txd_d = sh_d[0];
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      count_q  <= 16'd0;
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      bidx_q   <= 3'd0;
      sh_q     <= 8'd0;
      txd_q    <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en && is_ram) ram_q[address[RAM_AW-1:0]] <= wdata;
    if (push) fifo_q[wr_ptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = 16'd0;
    if (is_ram) begin
      rdata = ram_q[address[RAM_AW-1:0]];
    end else begin
      case (address)
        STATUS_A: rdata = {13'd0, ovf_q, empty_bit, fifo_full};
        TIMER_A:  rdata = count_q;
        default:  rdata = 16'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_opc5ls_sysbus.sv
// Bench for opc5ls_sysbus: directed bring-up checks, then random bus traffic
// compared every cycle against a frame-timeline model of RAM, FIFO, timer and txd.
module tb_opc5ls_sysbus;

  localparam int C      = 4;
  localparam int DEPTH  = 4;
  localparam int RAM_AW = 11;

  logic        clk, reset_b, rnw;
  logic [15:0] address, wdata, rdata;
  logic        txd;

  int n_checks = 0;
  int n_errors = 0;

  opc5ls_sysbus #(.RAM_AW(RAM_AW), .CLKS_PER_BIT(C), .FIFO_AW(2)) dut (
    .clk(clk), .reset_b(reset_b), .address(address), .wdata(wdata),
    .rnw(rnw), .rdata(rdata), .txd(txd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each popped byte occupies a 10*C-cycle window starting at its pop edge.
  logic [15:0] ram_m [int];
  logic [7:0]  q_m [$];
  bit          ovf_m = 1'b0;
  logic [15:0] tmr_m = 16'd0;
  int          cyc_m = 0;
  int          fstart_m = 0;
  bit          has_frame_m = 1'b0;
  logic [7:0]  fbyte_m = 8'd0;

  function automatic bit busy_at(int n);
    return has_frame_m && ((n - fstart_m) < 10 * C);
  endfunction

  function automatic logic exp_txd();
    int k;
    if (!busy_at(cyc_m)) return 1'b1;
    k = (cyc_m - fstart_m) / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return fbyte_m[k-1];
  endfunction

  task automatic exp_rdata(output logic [15:0] v, output bit known);
    bit empty;
    known = 1'b1;
    v = 16'd0;
    empty = (q_m.size() == 0) && !busy_at(cyc_m);
    if ((address >> RAM_AW) == 16'd0) begin
      if (ram_m.exists(int'(address))) v = ram_m[int'(address)];
      else known = 1'b0;
    end else if (address == 16'hFE01) begin
      v = {13'd0, ovf_m, empty, q_m.size() == DEPTH};
    end else if (address == 16'hFE02) begin
      v = tmr_m;
    end
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      q_m.delete();
      ovf_m = 1'b0;
      tmr_m = 16'd0;
      cyc_m = 0;
      has_frame_m = 1'b0;
    end else begin
      int  pre;
      bit  do_pop;
      pre    = q_m.size();
      do_pop = !busy_at(cyc_m) && (pre > 0);
      cyc_m++;
      tmr_m = tmr_m + 16'd1;
      if (!rnw) begin
        if ((address >> RAM_AW) == 16'd0) ram_m[int'(address)] = wdata;
        else if (address == 16'hFE00) begin
          if (pre == DEPTH) ovf_m = 1'b1;
          else q_m.push_back(wdata[7:0]);
        end else if (address == 16'hFE01) ovf_m = 1'b0;
        else if (address == 16'hFE02) tmr_m = wdata;
      end
      if (do_pop) begin
        fbyte_m = q_m.pop_front();
        fstart_m = cyc_m;
        has_frame_m = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    logic [15:0] v;
    bit known;
    #2;
    check("txd_model", {15'd0, txd}, {15'd0, exp_txd()});
    exp_rdata(v, known);
    if (known) check("rdata_model", rdata, v);
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] w, input logic r);
    @(negedge clk);
    address = a;
    wdata   = w;
    rnw     = r;
  endtask

  logic [0:39] pat;

  initial begin
    pat     = 40'b0000_1111_0000_1111_0000_0000_1111_0000_1111_1111;
    reset_b = 1'b0;
    rnw     = 1'b1;
    address = 16'hFE01;
    wdata   = 16'd0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    #1 check("reset_status", rdata, 16'h0002);
    check("reset_txd", {15'd0, txd}, 16'd1);
    address = 16'hFE02;
    #1 check("timer_t0", rdata, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #3 check("timer_run", rdata, 16'(i));
    end

    drive(16'h0005, 16'h1234, 1'b0);
    drive(16'h0000, 16'h5555, 1'b0);
    drive(16'h0005, 16'h0000, 1'b1);
    #1 check("ram_rw", rdata, 16'h1234);
    drive(16'hF000, 16'hBEEF, 1'b0);
    drive(16'hF000, 16'h0000, 1'b1);
    #1 check("unmapped_read", rdata, 16'h0000);
    drive(16'h0000, 16'h0000, 1'b1);
    #1 check("unmapped_no_alias", rdata, 16'h5555);

    // Single frame of 0xA5.
    drive(16'hFE00, 16'h00A5, 1'b0);
    drive(16'hFE01, 16'h0000, 1'b1);
    #1 check("status_queued", rdata, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #3 check("frame_a5_txd", {15'd0, txd}, {15'd0, pat[i]});
      if (i == 0) check("status_busy", rdata, 16'h0000);
    end
    @(posedge clk);
    #3 check("status_after_stop", rdata, 16'h0002);

    // Overflow: one byte in the shifter, four in the FIFO, sixth dropped.
    for (int i = 0; i < 5; i++) drive(16'hFE00, 16'(8'h11 + i), 1'b0);
    drive(16'hFE01, 16'h0000, 1'b1);
    #1 check("status_full", rdata, 16'h0001);
    drive(16'hFE00, 16'h0016, 1'b0);
    drive(16'hFE01, 16'h0000, 1'b1);
    #1 check("status_ovf", rdata, 16'h0005);
    drive(16'hFE01, 16'h0000, 1'b0);
    drive(16'hFE01, 16'h0000, 1'b1);
    #1 check("status_ovf_clr", rdata, 16'h0001);
    repeat (5 * 41 + 5) drive(16'hFE01, 16'h0000, 1'b1);
    #1 check("status_drained", rdata, 16'h0002);

    // Timer load and wrap.
    drive(16'hFE02, 16'hFFFE, 1'b0);
    drive(16'hFE02, 16'h0000, 1'b1);
    #1 check("timer_load", rdata, 16'hFFFE);
    drive(16'hFE02, 16'h0000, 1'b1);
    #1 check("timer_ffff", rdata, 16'hFFFF);
    drive(16'hFE02, 16'h0000, 1'b1);
    #1 check("timer_wrap", rdata, 16'h0000);
    drive(16'hFE02, 16'h0000, 1'b1);
    #1 check("timer_after_wrap", rdata, 16'h0001);

    // Random traffic; the compare process does the checking.
    for (int i = 0; i < 2500; i++) begin
      int sel;
      logic [15:0] a;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: a = 16'($urandom_range(0, 15));
        3:       a = 16'($urandom_range(2044, 2049));
        4:       a = 16'hFE00;
        5:       a = 16'hFE01;
        6:       a = 16'hFE02;
        7:       a = 16'($urandom_range(16'hFE03, 16'hFE05));
        default: a = 16'($urandom);
      endcase
      drive(a, 16'($urandom), 1'($urandom_range(0, 1)));
    end
    repeat (5 * 41 + 10) drive(16'hFE01, 16'h0000, 1'b1);
    #1 check("status_idle_after_random", rdata, 16'h0002);

    // Async reset in the middle of a DATA bit.
    drive(16'hFE00, 16'h0000, 1'b0);
    drive(16'hFE00, 16'h000F, 1'b0);
    drive(16'hFE01, 16'h0000, 1'b1);
    repeat (6) @(posedge clk);
    #3 check("mid_data_txd", {15'd0, txd}, 16'd0);
    reset_b = 1'b0;
    #1 check("reset_txd_async", {15'd0, txd}, 16'd1);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    #1 check("status_after_reset", rdata, 16'h0002);
    repeat (60) drive(16'hFE01, 16'h0000, 1'b1);
    #1 check("txd_quiet_after_reset", {15'd0, txd}, 16'd1);
    check("status_quiet_after_reset", rdata, 16'h0002);

    @(posedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
